// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl
//   Sequences capture of packed 4x14-bit ADC words into the sample BRAM write
//   port on the 62 MHz domain. A host start arms the block. The next qualifying
//   valid word begins a frame of i_frame_len words. Those words go to
//   consecutive (wrapping) addresses from i_base_addr. The block then holds DONE
//   until the host acknowledges.
//
//   Optional feature macro: ADCCAP_TRIG_EN
//     defined   - a lane-0 level trigger (i_trig_level / i_trig_rise) qualifies
//                 the first word; earlier words are discarded.
//     undefined - free-run: the first valid word after start begins the frame.
//
// Ports
//   i_62clk       capture clock, rising edge
//   i_nreset      asynchronous active-low reset
//   i_start       arm pulse (honoured only in IDLE); samples len/base
//   i_abort       cancel pulse for ARMED/CAPTURE
//   i_frame_len   words per frame, 0 means 2^ADDR_W
//   i_base_addr   first write address
//   i_word        packed sample word, i_word_valid qualifies it
//   i_done_ack    host release of DONE
//   i_trig_level  (ADCCAP_TRIG_EN) lane-0 trigger threshold
//   i_trig_rise   (ADCCAP_TRIG_EN) 1: lane0 >= level, 0: lane0 <= level
//   o_wr_addr/o_wr_data/o_wr_en/o_byteen  BRAM write port
//   o_busy        ARMED or CAPTURE
//   o_done        DONE
//   o_overrun     sticky, a valid word was dropped while DONE
//   o_word_count  words written in the current/last frame
//   o_frame_id    completed-frame counter, wraps
module adc_capture_ctrl #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 64,
  parameter int BE_W   = 8
) (
  input  logic              i_62clk,
  input  logic              i_nreset,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [ADDR_W-1:0] i_frame_len,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [DATA_W-1:0] i_word,
  input  logic              i_word_valid,
  input  logic              i_done_ack,
`ifdef ADCCAP_TRIG_EN
  input  logic [13:0]       i_trig_level,
  input  logic              i_trig_rise,
`endif
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic              o_wr_en,
  output logic [BE_W-1:0]   o_byteen,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_overrun,
  output logic [ADDR_W:0]   o_word_count,
  output logic [7:0]        o_frame_id
);

  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_CAPTURE, ST_DONE} state_t;

  state_t            state, next_state;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   count_plus;
  logic              arm_ok;
  logic              accept_start;
  logic              take;
  logic              last_word;

  assign count_plus = o_word_count + 1'b1;
  assign last_word  = (count_plus == len_q);

`ifdef ADCCAP_TRIG_EN
  // Lane 0 sits in the low 14 bits of the packed word.
  assign arm_ok = i_trig_rise ? (i_word[13:0] >= i_trig_level)
                              : (i_word[13:0] <= i_trig_level);
`else
  assign arm_ok = 1'b1;
`endif

  always_ff @(posedge i_62clk or negedge i_nreset) begin
    if (!i_nreset) state <= ST_IDLE;
    else           state <= next_state;
  end

  // Abort is checked before any word acceptance, so it beats a simultaneous
  // frame completion.
  always_comb begin
    next_state   = state;
    accept_start = 1'b0;
    take         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_start) begin
          accept_start = 1'b1;
          next_state   = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (i_abort) begin
          next_state = ST_IDLE;
        end else if (i_word_valid && arm_ok) begin
          take       = 1'b1;
          next_state = last_word ? ST_DONE : ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (i_abort) begin
          next_state = ST_IDLE;
        end else if (i_word_valid) begin
          take = 1'b1;
          if (last_word) next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        if (i_done_ack) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Write port and frame bookkeeping. The frame id is bumped on the same edge
  // that enters DONE, so both are visible together.
  always_ff @(posedge i_62clk or negedge i_nreset) begin
    if (!i_nreset) begin
      o_wr_addr    <= '0;
      o_wr_data    <= '0;
      o_wr_en      <= 1'b0;
      o_overrun    <= 1'b0;
      o_word_count <= '0;
      o_frame_id   <= '0;
      len_q        <= '0;
      base_q       <= '0;
    end else begin
      o_wr_en <= take;
      if (accept_start) begin
        len_q        <= (i_frame_len == '0) ? {1'b1, {ADDR_W{1'b0}}}
                                            : {1'b0, i_frame_len};
        base_q       <= i_base_addr;
        o_word_count <= '0;
        o_overrun    <= 1'b0;
      end
      if (take) begin
        o_wr_addr    <= base_q + o_word_count[ADDR_W-1:0];
        o_wr_data    <= i_word;
        o_word_count <= count_plus;
        if (last_word) o_frame_id <= o_frame_id + 8'd1;
      end
      if (state == ST_DONE && i_word_valid) o_overrun <= 1'b1;
    end
  end

  assign o_byteen = {BE_W{o_wr_en}};
  assign o_busy   = (state == ST_ARMED) || (state == ST_CAPTURE);
  assign o_done   = (state == ST_DONE);

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Testbench for adc_capture_ctrl. Expected BRAM writes are queued when a word
// that must be written is driven. A negedge monitor pops the queue and compares
// each write it observes.
module tb_adc_capture_ctrl;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 64;
  localparam int BE_W   = 8;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic              i_62clk = 1'b0;
  logic              i_nreset;
  logic              i_start, i_abort, i_word_valid, i_done_ack;
  logic [ADDR_W-1:0] i_frame_len, i_base_addr;
  logic [DATA_W-1:0] i_word;
`ifdef ADCCAP_TRIG_EN
  logic [13:0]       i_trig_level;
  logic              i_trig_rise;
`endif
  logic [ADDR_W-1:0] o_wr_addr;
  logic [DATA_W-1:0] o_wr_data;
  logic              o_wr_en, o_busy, o_done, o_overrun;
  logic [BE_W-1:0]   o_byteen;
  logic [ADDR_W:0]   o_word_count;
  logic [7:0]        o_frame_id;

  int  checks = 0;
  int  failures = 0;
  int  writes_seen = 0;
  wr_t exp_q[$];

  adc_capture_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) dut (
    .i_62clk(i_62clk), .i_nreset(i_nreset), .i_start(i_start), .i_abort(i_abort),
    .i_frame_len(i_frame_len), .i_base_addr(i_base_addr), .i_word(i_word),
    .i_word_valid(i_word_valid), .i_done_ack(i_done_ack),
`ifdef ADCCAP_TRIG_EN
    .i_trig_level(i_trig_level), .i_trig_rise(i_trig_rise),
`endif
    .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .o_wr_en(o_wr_en),
    .o_byteen(o_byteen), .o_busy(o_busy), .o_done(o_done), .o_overrun(o_overrun),
    .o_word_count(o_word_count), .o_frame_id(o_frame_id)
  );

  always #8 i_62clk = ~i_62clk;

  // Scoreboard monitor: every observed write must match the queue head, and
  // byte enables must track the write enable.
  always @(negedge i_62clk) begin
    if (i_nreset) begin
      if (o_wr_en) begin
        wr_t e;
        writes_seen++;
        checks++;
        if (o_byteen !== 8'hFF) begin
          failures++;
          $display("[TB] FAIL byteen_on got=%h want=ff", o_byteen);
        end
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpected_write got addr=%0d data=%h want no write", o_wr_addr, o_wr_data);
        end else begin
          e = exp_q.pop_front();
          if (o_wr_addr !== e.addr || o_wr_data !== e.data) begin
            failures++;
            $display("[TB] FAIL write got addr=%0d data=%h want addr=%0d data=%h",
                     o_wr_addr, o_wr_data, e.addr, e.data);
          end
        end
      end else begin
        checks++;
        if (o_byteen !== 8'h00) begin
          failures++;
          $display("[TB] FAIL byteen_off got=%h want=00", o_byteen);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge i_62clk);
    #1;
  endtask

  task automatic drive_word(input logic [DATA_W-1:0] w, input bit expect_wr,
                            input logic [ADDR_W-1:0] addr);
    wr_t e;
    i_word       = w;
    i_word_valid = 1'b1;
    if (expect_wr) begin
      e.addr = addr;
      e.data = w;
      exp_q.push_back(e);
    end
    tick();
  endtask

  task automatic start_frame(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] len);
    i_base_addr = base;
    i_frame_len = len;
    i_start     = 1'b1;
    tick();
    i_start     = 1'b0;
  endtask

  task automatic ack_frame();
    i_done_ack = 1'b1;
    tick();
    i_done_ack = 1'b0;
  endtask

  task automatic test_reset();
    i_nreset = 1'b0;
    i_start = 0; i_abort = 0; i_word_valid = 0; i_done_ack = 0;
    i_frame_len = '0; i_base_addr = '0; i_word = '0;
`ifdef ADCCAP_TRIG_EN
    i_trig_level = '0; i_trig_rise = 1'b1;
`endif
    #20;
    checks++;
    if ({o_wr_addr, o_wr_data, o_wr_en, o_byteen, o_busy, o_done, o_overrun, o_word_count, o_frame_id} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got addr=%0d en=%b busy=%b done=%b cnt=%0d id=%0d want all 0",
               o_wr_addr, o_wr_en, o_busy, o_done, o_word_count, o_frame_id);
    end
    tick();
    i_nreset = 1'b1;
    tick();
    // An ack outside DONE has no effect.
    ack_frame();
    checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL idle_ack got busy=%b done=%b want 0 0", o_busy, o_done);
    end
  endtask

  task automatic test_free_run();
    logic [DATA_W-1:0] w;
    start_frame(14'd0, 14'd4);
    checks++;
    if (o_busy !== 1'b1 || o_done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL armed_busy got busy=%b done=%b want 1 0", o_busy, o_done);
    end
    for (int i = 0; i < 4; i++) begin
      w = {$urandom, $urandom};
      drive_word(w, 1'b1, ADDR_W'(i));
    end
    i_word_valid = 1'b0;
    checks++;
    if (o_done !== 1'b1 || o_wr_en !== 1'b1 || o_word_count !== 15'd4 || o_frame_id !== 8'd1) begin
      failures++;
      $display("[TB] FAIL free_run_done got done=%b en=%b cnt=%0d id=%0d want 1 1 4 1",
               o_done, o_wr_en, o_word_count, o_frame_id);
    end
    tick();
    ack_frame();
    checks++;
    if (o_done !== 1'b0 || o_busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL free_run_ack got done=%b busy=%b want 0 0", o_done, o_busy);
    end
  endtask

  task automatic test_wrap();
    logic [ADDR_W-1:0] base;
    base = 14'd16382;
    start_frame(base, 14'd4);
    for (int i = 0; i < 4; i++)
      drive_word({$urandom, $urandom}, 1'b1, base + ADDR_W'(i));
    i_word_valid = 1'b0;
    tick();
    checks++;
    if (o_done !== 1'b1 || o_frame_id !== 8'd2) begin
      failures++;
      $display("[TB] FAIL wrap_done got done=%b id=%0d want 1 2", o_done, o_frame_id);
    end
    ack_frame();
  endtask

  task automatic test_gapped();
    bit pattern[7] = '{1, 0, 0, 1, 1, 0, 1};
    int w0, k;
    w0 = writes_seen;
    k  = 0;
    start_frame(14'd100, 14'd4);
    foreach (pattern[i]) begin
      if (pattern[i]) begin
        drive_word({$urandom, $urandom}, 1'b1, 14'd100 + ADDR_W'(k));
        k++;
      end else begin
        i_word_valid = 1'b0;
        tick();
      end
    end
    i_word_valid = 1'b0;
    @(negedge i_62clk);
    #1;
    checks++;
    if (writes_seen - w0 !== 4 || o_done !== 1'b1 || o_word_count !== 15'd4 || o_frame_id !== 8'd3) begin
      failures++;
      $display("[TB] FAIL gapped got writes=%0d done=%b cnt=%0d id=%0d want 4 1 4 3",
               writes_seen - w0, o_done, o_word_count, o_frame_id);
    end
  endtask

  // Continues from DONE left by test_gapped.
  task automatic test_overrun();
    drive_word({$urandom, $urandom}, 1'b0, '0);
    i_done_ack = 1'b1;
    drive_word({$urandom, $urandom}, 1'b0, '0);
    i_done_ack   = 1'b0;
    i_word_valid = 1'b0;
    checks++;
    if (o_overrun !== 1'b1 || o_done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL overrun_set got ovr=%b done=%b want 1 0", o_overrun, o_done);
    end
    tick();
    tick();
    checks++;
    if (o_overrun !== 1'b1) begin
      failures++;
      $display("[TB] FAIL overrun_sticky got=%b want=1", o_overrun);
    end
  endtask

  task automatic test_abort();
    int w0;
    w0 = writes_seen;
    start_frame(14'd500, 14'd8);
    checks++;
    if (o_overrun !== 1'b0) begin
      failures++;
      $display("[TB] FAIL overrun_clear got=%b want=0", o_overrun);
    end
    for (int i = 0; i < 3; i++)
      drive_word({$urandom, $urandom}, 1'b1, 14'd500 + ADDR_W'(i));
    i_abort = 1'b1;
    drive_word({$urandom, $urandom}, 1'b0, '0);
    i_abort = 1'b0;
    checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL abort_idle got busy=%b done=%b want 0 0", o_busy, o_done);
    end
    drive_word({$urandom, $urandom}, 1'b0, '0);
    drive_word({$urandom, $urandom}, 1'b0, '0);
    i_word_valid = 1'b0;
    @(negedge i_62clk);
    #1;
    checks++;
    if (writes_seen - w0 !== 3 || o_word_count !== 15'd3 || o_frame_id !== 8'd3) begin
      failures++;
      $display("[TB] FAIL abort_counts got writes=%0d cnt=%0d id=%0d want 3 3 3",
               writes_seen - w0, o_word_count, o_frame_id);
    end
  endtask

  task automatic test_async_reset();
    tick();
    start_frame(14'd0, 14'd8);
    drive_word({$urandom, $urandom}, 1'b1, 14'd0);
    drive_word({$urandom, $urandom}, 1'b1, 14'd1);
    i_word_valid = 1'b0;
    @(negedge i_62clk);
    #1;
    checks++;
    if (o_wr_en !== 1'b1 || o_busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL pre_reset got en=%b busy=%b want 1 1", o_wr_en, o_busy);
    end
    i_nreset = 1'b0;
    #1;
    checks++;
    if ({o_wr_addr, o_wr_data, o_wr_en, o_byteen, o_busy, o_done, o_overrun, o_word_count, o_frame_id} !== '0) begin
      failures++;
      $display("[TB] FAIL async_reset got en=%b be=%h busy=%b cnt=%0d id=%0d want all 0",
               o_wr_en, o_byteen, o_busy, o_word_count, o_frame_id);
    end
    tick();
    i_nreset = 1'b1;
    tick();
  endtask

`ifdef ADCCAP_TRIG_EN
  task automatic test_trigger();
    logic [13:0] lane0[5] = '{14'd1, 14'd1, 14'd1000, 14'd1000, 14'd1};
    logic [DATA_W-1:0] w;
    i_trig_level = 14'd1000;
    i_trig_rise  = 1'b1;
    start_frame(14'd20, 14'd2);
    for (int i = 0; i < 5; i++) begin
      w = {$urandom, $urandom};
      w[13:0] = lane0[i];
      drive_word(w, (i == 2 || i == 3), 14'd20 + ADDR_W'(i - 2));
    end
    i_word_valid = 1'b0;
    checks++;
    if (o_done !== 1'b1 || o_word_count !== 15'd2 || o_frame_id !== 8'd1 || o_overrun !== 1'b1) begin
      failures++;
      $display("[TB] FAIL trigger got done=%b cnt=%0d id=%0d ovr=%b want 1 2 1 1",
               o_done, o_word_count, o_frame_id, o_overrun);
    end
    ack_frame();
  endtask
`endif

  initial begin
    test_reset();
    test_free_run();
    test_wrap();
    test_gapped();
    test_overrun();
    test_abort();
    test_async_reset();
`ifdef ADCCAP_TRIG_EN
    test_trigger();
`endif
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL missing_writes got pending=%0d want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
